// File: rtl/murax_shift_out_if.sv
// APB3 slave bus bundle for the shiftOut peripheral.
interface murax_shift_out_if;
  logic [3:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/murax_shift_out.sv
// Arduino-style shiftOut APB3 peripheral: divided bit clock, bit order, one-deep hold register.
// Optional interrupt output enabled by defining SHIFT_OUT_IRQ_EN.
module murax_shift_out #(
  parameter logic [15:0] DEFAULT_DIV = 16'd11
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset,
  murax_shift_out_if.slave apb,
  output logic             io_shiftOut_dataPin,
  output logic             io_shiftOut_clockPin
`ifdef SHIFT_OUT_IRQ_EN
  ,
  output logic             io_interrupt
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH} state_t;

  state_t      state;
  logic [7:0]  shifter;
  logic [7:0]  hold_reg;
  logic        hold_full;
  logic        overrun;
  logic        msb_first;
  logic [15:0] div;
  logic        sh_msb;
  logic [15:0] sh_div;
  logic [15:0] phase_cnt;
  logic [2:0]  bit_cnt;
  logic        data_pin;
  logic        clock_pin;
  logic        irq_en;

  logic        wr;
  logic        wr_data;
  logic        wr_ctrl;
  logic        wr_status;
  logic        busy;
  logic        phase_done;
  logic        byte_done;
  logic        do_load;
  logic [7:0]  load_byte;
  logic [31:0] prdata;
  logic        unused_bits;

  assign wr        = apb.psel & apb.penable & apb.pwrite;
  assign wr_data   = wr & (apb.paddr == 4'h0);
  assign wr_ctrl   = wr & (apb.paddr == 4'h4);
  assign wr_status = wr & (apb.paddr == 4'h8);

  assign busy       = (state != IDLE);
  assign phase_done = (phase_cnt == sh_div);
  assign byte_done  = (state == HIGH) & phase_done & (bit_cnt == 3'd7);

  // A write landing on the last HIGH cycle with an empty hold register is
  // loaded straight into the shifter, so it is never stranded while idle.
  assign do_load   = ((state == IDLE) & wr_data) | (byte_done & (hold_full | wr_data));
  assign load_byte = hold_full ? hold_reg : apb.pwdata[7:0];

  assign unused_bits = &{1'b0, apb.pwdata[15:1]};

  always_comb begin
    prdata = 32'h0;
    if (apb.psel) begin
      case (apb.paddr)
        4'h4:    prdata = {div, 14'b0, irq_en, msb_first};
        4'h8:    prdata = {29'b0, overrun, hold_full, busy};
        default: prdata = 32'h0;
      endcase
    end
  end

  assign apb.prdata           = prdata;
  assign apb.pready           = 1'b1;
  assign io_shiftOut_dataPin  = data_pin;
  assign io_shiftOut_clockPin = clock_pin;

`ifdef SHIFT_OUT_IRQ_EN
  logic irq_reg;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      irq_en  <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= apb.pwdata[1];
      irq_reg <= irq_en & ~busy & ~hold_full;
    end
  end

  assign io_interrupt = irq_reg;
`else
  assign irq_en = 1'b0;
`endif

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state     <= IDLE;
      shifter   <= 8'h0;
      hold_reg  <= 8'h0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      msb_first <= 1'b0;
      div       <= DEFAULT_DIV;
      sh_msb    <= 1'b0;
      sh_div    <= 16'h0;
      phase_cnt <= 16'h0;
      bit_cnt   <= 3'd0;
      data_pin  <= 1'b0;
      clock_pin <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        msb_first <= apb.pwdata[0];
        div       <= apb.pwdata[31:16];
      end

      // A new overrun beats a simultaneous clear.
      if (wr_data & busy & hold_full)
        overrun <= 1'b1;
      else if (wr_status & apb.pwdata[2])
        overrun <= 1'b0;

      if (wr_data & busy & ~hold_full & ~byte_done) begin
        hold_reg  <= apb.pwdata[7:0];
        hold_full <= 1'b1;
      end

      if (do_load) begin
        shifter   <= load_byte;
        data_pin  <= msb_first ? load_byte[7] : load_byte[0];
        sh_msb    <= msb_first;
        sh_div    <= div;
        phase_cnt <= 16'h0;
        bit_cnt   <= 3'd0;
        clock_pin <= 1'b0;
        state     <= SETUP;
        if (byte_done & hold_full) hold_full <= 1'b0;
      end else begin
        case (state)
          SETUP: begin
            if (phase_done) begin
              phase_cnt <= 16'h0;
              clock_pin <= 1'b1;
              state     <= HIGH;
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end
          HIGH: begin
            if (phase_done) begin
              phase_cnt <= 16'h0;
              clock_pin <= 1'b0;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                shifter  <= sh_msb ? {shifter[6:0], 1'b0} : {1'b0, shifter[7:1]};
                data_pin <= sh_msb ? shifter[6] : shifter[1];
                state    <= SETUP;
              end else begin
                state <= IDLE;
              end
            end else begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end
          default: begin
            clock_pin <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_murax_shift_out.sv
// Directed self-checking bench for murax_shift_out.
module tb_murax_shift_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_pin;
  logic clock_pin;
`ifdef SHIFT_OUT_IRQ_EN
  logic irq;
`endif

  murax_shift_out_if apb ();

  murax_shift_out #(.DEFAULT_DIV(16'd11)) dut (
    .io_mainClk          (clk),
    .io_asyncReset       (rst),
    .apb                 (apb.slave),
    .io_shiftOut_dataPin (data_pin),
    .io_shiftOut_clockPin(clock_pin)
`ifdef SHIFT_OUT_IRQ_EN
    ,
    .io_interrupt        (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  bit bits[$];
  int edge_cyc[$];

  always @(posedge clk) cyc++;

  always @(posedge clock_pin) begin
    bits.push_back(data_pin);
    edge_cyc.push_back(cyc);
  end

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(negedge clk);
    apb.penable = 1'b1;
    @(posedge clk);
    #1 wr_cyc = cyc;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    #1 data = apb.prdata;
    apb.psel = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int busy_cnt, output bit timed_out);
    logic [31:0] d;
    busy_cnt = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      apb_read(4'h8, d);
      if (!d[0]) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] collect_msb();
    logic [15:0] v = 16'h0;
    foreach (bits[i]) v = {v[14:0], bits[i]};
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    #2;
    n_checks++;
    if ({clock_pin, data_pin} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pins: got %b expected 00", {clock_pin, data_pin});
    end
    n_checks++;
    if (apb.prdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_prdata_nosel: got %h expected 00000000", apb.prdata);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    apb_read(4'h8, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: got %h expected 00000000", d);
    end
    apb_read(4'h4, d);
    n_checks++;
    if (d !== 32'h000B_0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 000b0000", d);
    end
    $display("test_reset: pins=%b ctrl=%h", {clock_pin, data_pin}, d);
  endtask

  task automatic test_msb_first();
    int cnt; bit to; logic [15:0] v;
    apb_write(4'h4, {16'd1, 16'h0001});
    bits.delete(); edge_cyc.delete();
    apb_write(4'h0, 32'hA5);
    wait_idle(200, cnt, to);
    n_checks++;
    if (to || cnt != 32) begin
      n_fail++; $display("FAIL msb_busy_cycles: got %0d (timeout %0d) expected 32", cnt, to);
    end
    v = collect_msb();
    n_checks++;
    if (bits.size() != 8 || v[7:0] !== 8'hA5) begin
      n_fail++; $display("FAIL msb_bits: got %0d edges value %h expected 8 edges a5", bits.size(), v[7:0]);
    end
    n_checks++;
    if (edge_cyc.size() == 0 || edge_cyc[0] - wr_cyc != 2) begin
      n_fail++; $display("FAIL msb_first_edge: got %0d expected 2", edge_cyc.size() ? edge_cyc[0] - wr_cyc : -1);
    end
    for (int i = 1; i < edge_cyc.size(); i++) begin
      n_checks++;
      if (edge_cyc[i] - edge_cyc[i-1] != 4) begin
        n_fail++; $display("FAIL msb_edge_spacing: edge %0d got %0d expected 4", i, edge_cyc[i] - edge_cyc[i-1]);
      end
    end
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({clock_pin, data_pin} !== 2'b01) begin
      n_fail++; $display("FAIL msb_rest_pins: got %b expected 01", {clock_pin, data_pin});
    end
    $display("test_msb_first: busy=%0d bits=%h", cnt, v[7:0]);
  endtask

  task automatic test_lsb_first();
    int cnt; bit to; logic [7:0] v;
    apb_write(4'h4, 32'h0000_0000);
    bits.delete(); edge_cyc.delete();
    apb_write(4'h0, 32'h01);
    wait_idle(200, cnt, to);
    n_checks++;
    if (to || cnt != 16) begin
      n_fail++; $display("FAIL lsb_busy_cycles: got %0d (timeout %0d) expected 16", cnt, to);
    end
    v = 8'h0;
    foreach (bits[i]) v = {bits[i], v[7:1]};
    n_checks++;
    if (bits.size() != 8 || v !== 8'h01 || bits[0] !== 1'b1) begin
      n_fail++; $display("FAIL lsb_bits: got %0d edges value %h expected 8 edges 01", bits.size(), v);
    end
    $display("test_lsb_first: busy=%0d bits=%h", cnt, v);
  endtask

  task automatic test_back_to_back();
    int cnt; bit to; logic [31:0] d; logic [15:0] v;
    apb_write(4'h4, {16'd2, 16'h0001});
    bits.delete(); edge_cyc.delete();
    apb_write(4'h0, 32'h0F);
    apb_write(4'h0, 32'hF0);
    apb_write(4'h0, 32'h33);
    apb_read(4'h8, d);
    n_checks++;
    if (d !== 32'h7) begin
      n_fail++; $display("FAIL overrun_status: got %h expected 00000007", d);
    end
    apb_write(4'h8, 32'h4);
    apb_read(4'h8, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++; $display("FAIL overrun_clear: got %h expected 00000003", d);
    end
    wait_idle(400, cnt, to);
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL b2b_timeout: got busy %0d cycles expected idle", cnt);
    end
    v = collect_msb();
    n_checks++;
    if (bits.size() != 16 || v !== 16'h0FF0) begin
      n_fail++; $display("FAIL b2b_bits: got %0d edges value %h expected 16 edges 0ff0", bits.size(), v);
    end
    n_checks++;
    if (edge_cyc.size() != 16 || edge_cyc[15] - edge_cyc[0] != 15 * 6) begin
      n_fail++; $display("FAIL b2b_contiguous: got span %0d expected 90", edge_cyc.size() == 16 ? edge_cyc[15] - edge_cyc[0] : -1);
    end
    $display("test_back_to_back: bits=%h edges=%0d", v, bits.size());
  endtask

  task automatic test_shadow();
    int cnt; bit to; logic [15:0] v;
    apb_write(4'h4, {16'd1, 16'h0001});
    bits.delete(); edge_cyc.delete();
    apb_write(4'h0, 32'hFF);
    apb_write(4'h0, 32'h00);
    apb_write(4'h4, {16'd3, 16'h0001});
    wait_idle(400, cnt, to);
    v = collect_msb();
    n_checks++;
    if (to || bits.size() != 16 || v !== 16'hFF00) begin
      n_fail++; $display("FAIL shadow_bits: got %0d edges value %h expected 16 edges ff00", bits.size(), v);
    end
    if (edge_cyc.size() == 16) begin
      n_checks++;
      if (edge_cyc[7] - edge_cyc[6] != 4) begin
        n_fail++; $display("FAIL shadow_old_div: got %0d expected 4", edge_cyc[7] - edge_cyc[6]);
      end
      n_checks++;
      if (edge_cyc[8] - edge_cyc[7] != 6) begin
        n_fail++; $display("FAIL shadow_switch: got %0d expected 6", edge_cyc[8] - edge_cyc[7]);
      end
      n_checks++;
      if (edge_cyc[15] - edge_cyc[14] != 8) begin
        n_fail++; $display("FAIL shadow_new_div: got %0d expected 8", edge_cyc[15] - edge_cyc[14]);
      end
    end
    $display("test_shadow: bits=%h edges=%0d", v, bits.size());
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; bit reached; int n;
    apb_write(4'h4, {16'd1, 16'h0001});
    bits.delete(); edge_cyc.delete();
    apb_write(4'h0, 32'hFF);
    apb_write(4'h0, 32'hFF);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bits.size() >= 3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL abort_progress: got %0d edges expected 3", bits.size());
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({clock_pin, data_pin} !== 2'b00) begin
      n_fail++; $display("FAIL abort_pins: got %b expected 00", {clock_pin, data_pin});
    end
    apb_read(4'h8, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL abort_status: got %h expected 00000000", d);
    end
    apb_read(4'h4, d);
    n_checks++;
    if (d !== 32'h000B_0000) begin
      n_fail++; $display("FAIL abort_ctrl: got %h expected 000b0000", d);
    end
    @(negedge clk); rst = 1'b0;
    n = bits.size();
    repeat (60) @(negedge clk);
    n_checks++;
    if (bits.size() != n || {clock_pin, data_pin} !== 2'b00) begin
      n_fail++; $display("FAIL abort_discard: got %0d new edges pins %b expected 0 new edges pins 00", bits.size() - n, {clock_pin, data_pin});
    end
    $display("test_reset_abort: edges_before=%0d ctrl=%h", n, d);
  endtask

`ifdef SHIFT_OUT_IRQ_EN
  task automatic test_irq();
    int cnt; bit to; logic seen_high;
    apb_write(4'h4, {16'd0, 16'h0003});
    apb_write(4'h0, 32'h55);
    seen_high = 1'b0;
    cnt = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!dut.busy) begin to = 1'b0; break; end
      if (irq) seen_high = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (to || seen_high) begin
      n_fail++; $display("FAIL irq_during: got high=%0d timeout=%0d expected 0 0", seen_high, to);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_entry_cycle: got %b expected 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_rise: got %b expected 1", irq);
    end
    apb_write(4'h0, 32'h01);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_drop: got %b expected 0", irq);
    end
    wait_idle(200, cnt, to);
    $display("test_irq: irq=%b", irq);
  endtask
`endif

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 4'h0; apb.pwdata = 32'h0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_shadow();
    test_reset_abort();
`ifdef SHIFT_OUT_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
